// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES chunks, one chunk
// resolved per clock, with an elastic valid/ready handshake on both sides.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  // Stage registers: valid, partial result, running carry, operands still to add
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic              ovf_q;

  // Inputs seen by each stage (stage 0 from the ports, stage k from stage k-1)
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_r [STAGES];
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];

  // Next-state values computed by each stage
  logic [STAGES-1:0] c_d;
  logic [WIDTH-1:0]  r_d [STAGES];
  logic              ovf_d;
  logic [CHUNK-1:0]  sum_c;

  // Load enables: a stage may be overwritten when empty or when it drains onward
  logic [STAGES-1:0] en;

  // Ready chain, evaluated from the output back towards the input
  always_comb begin
    en = '0;
    en[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int unsigned k = STAGES - 1; k > 0; k--) begin
      en[k-1] = !v_q[k-1] || en[k];
    end
  end

  assign in_ready = en[0];

  // Route each stage's inputs; stage 0 forms effective b and carry-in
  always_comb begin
    src_v    = '0;
    src_c    = '0;
    src_v[0] = in_valid;
    src_c[0] = sub | cin;
    src_r[0] = '0;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_c[k] = c_q[k-1];
      src_r[k] = r_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
    end
  end

  // Per-stage chunk add; overflow uses the carry into the MSB recovered from the top bit
  always_comb begin
    c_d   = '0;
    sum_c = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      {c_d[k], sum_c} = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                      + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, src_c[k]};
      r_d[k] = src_r[k];
      r_d[k][k*CHUNK +: CHUNK] = sum_c;
    end
    ovf_d = (r_d[STAGES-1][WIDTH-1] ^ src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1])
          ^ c_d[STAGES-1];
  end

  // Pipeline registers; data only loads with a valid op so the last result stays put
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            c_q[k] <= c_d[k];
            r_q[k] <= r_d[k];
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
          end
        end
      end
      if (en[STAGES-1] && src_v[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign s         = r_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed table, streaming, backpressure,
// mid-flight reset, plus 8-bit builds with 1 and 8 stages swept under random out_ready.
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    res_t r;
    int   c;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void check(input string nm, input longint unsigned act,
                                input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Arithmetic reference: integer sum/difference and signed range test
  function automatic res_t ref_model(input int w, input longint ta, input longint tb,
                                     input bit tc, input bit ts);
    longint m, half, sa, sb, full, sres;
    res_t r;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (ta >= half) ? ta - 2 * half : ta;
    sb   = (tb >= half) ? tb - 2 * half : tb;
    r    = '0;
    if (ts) begin
      full   = ta - tb;
      r.cout = (ta >= tb);
      sres   = sa - sb;
    end else begin
      full   = ta + tb + longint'(tc);
      r.cout = (full > m);
      sres   = sa + sb + longint'(tc);
    end
    r.ovf = (sres < -half) || (sres >= half);
    r.s   = 32'(full & m);
    return r;
  endfunction

  // ---------------- main 32-bit / 4-stage DUT ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        cin, sub, cout, ovf;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  exp_t eq[$];
  res_t act_log[$];
  int   lat_log[$];

  always @(negedge clk) begin : main_sb
    res_t act;
    exp_t e;
    if (rst) begin
      eq.delete();
    end else begin
      if (out_valid && out_ready) begin
        act = {s, cout, ovf};
        check("main_pending", (eq.size() > 0), 1);
        if (eq.size() > 0) begin
          e = eq.pop_front();
          check("main_s", act.s, e.r.s);
          check("main_cout", act.cout, e.r.cout);
          check("main_ovf", act.ovf, e.r.ovf);
          lat_log.push_back(cyc - e.c);
        end
        act_log.push_back(act);
      end
      if (in_valid && in_ready) begin
        e.r = ref_model(32, a, b, cin, sub);
        e.c = cyc;
        eq.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                      input logic tc, input logic ts);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accept", ok, 1);
  endtask

  task automatic wait_out(input int target, input string nm);
    int n;
    n = 0;
    while (act_log.size() < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(nm, act_log.size(), target);
  endtask

  // ---------------- 8-bit builds: 1 stage and 8 stages ----------------
  for (genvar g = 0; g < 2; g++) begin : g_small
    localparam int ST = (g == 0) ? 1 : 8;
    logic       s_iv, s_ir, s_ov, s_or, s_ci, s_sub, s_co, s_of;
    logic [7:0] s_a, s_b, s_s;
    bit         done = 0;
    bit         sb_on = 0;
    bit         drv_done = 0;
    int         nacc = 0;
    int         nout = 0;
    res_t       q[$];

    pipelined_adder #(.WIDTH(8), .STAGES(ST)) u_small (
      .clk(clk), .rst(srst), .in_valid(s_iv), .in_ready(s_ir),
      .a(s_a), .b(s_b), .cin(s_ci), .sub(s_sub),
      .out_valid(s_ov), .out_ready(s_or),
      .s(s_s), .cout(s_co), .ovf(s_of)
    );

    always @(negedge clk) begin : small_sb
      res_t e;
      if (sb_on) begin
        if (s_ov && s_or) begin
          check("small_pending", (q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("small_s", s_s, e.s[7:0]);
            check("small_cout", s_co, e.cout);
            check("small_ovf", s_of, e.ovf);
          end
          nout++;
        end
        if (s_iv && s_ir) begin
          q.push_back(ref_model(8, s_a, s_b, s_ci, s_sub));
          nacc++;
        end
      end
    end

    initial begin : small_run
      int   lat, n;
      bit   ok;
      res_t e;
      logic [7:0] blist [8];
      blist = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
      s_iv = 0; s_or = 1; s_a = 0; s_b = 0; s_ci = 0; s_sub = 0;
      wait (srst == 1'b0);
      @(posedge clk);
      #1;
      // latency probe with out_ready held high
      s_a = 8'hFF; s_b = 8'h01; s_ci = 0; s_sub = 0; s_iv = 1;
      @(negedge clk);
      check("small_probe_ready", s_ir, 1);
      @(posedge clk);
      #1;
      s_iv = 0;
      lat = 1;
      while (!s_ov && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("small_latency", lat, ST);
      e = ref_model(8, 255, 1, 0, 0);
      check("small_probe_s", s_s, e.s[7:0]);
      check("small_probe_cout", s_co, e.cout);
      @(posedge clk);
      #1;
      check("small_probe_drained", s_ov, 0);
      sb_on = 1;
      fork
        begin
          for (int unsigned ai = 0; ai < 256; ai++) begin
            for (int unsigned bi = 0; bi < 9; bi++) begin
              for (int unsigned cs = 0; cs < 4; cs++) begin
                s_a   = 8'(ai);
                s_b   = (bi < 8) ? blist[bi] : 8'($urandom);
                s_ci  = cs[0];
                s_sub = cs[1];
                s_iv  = 1;
                ok = 0;
                n = 0;
                while (!ok && n < 200) begin
                  @(negedge clk);
                  ok = s_ir;
                  @(posedge clk);
                  #1;
                  n++;
                end
                if (!ok) check("small_accept", ok, 1);
              end
            end
          end
          s_iv = 0;
          drv_done = 1;
        end
        begin
          while (!drv_done) begin
            @(posedge clk);
            #1;
            s_or = ($urandom_range(0, 3) != 0);
          end
          s_or = 1;
        end
      join
      n = 0;
      while (nout < nacc && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("small_count", nout, 256 * 9 * 4);
      check("small_queue_empty", q.size(), 0);
      done = 1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main_run
    vec_t tbl [10];
    int   base, lbase, acc, bad, stale, n;
    bit   have;
    res_t hold;
    logic [31:0] pa, pb;
    logic pc, ps;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h80000001, 1'b0, 1'b1};
    tbl[4] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[5] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};
    tbl[7] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};
    tbl[8] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

    in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_s", s, 0);
    check("reset_cout", cout, 0);
    check("reset_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst = 0;
    srst = 0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // directed table, back-to-back
    base = act_log.size();
    lbase = lat_log.size();
    for (int i = 0; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
    in_valid = 0;
    wait_out(base + 10, "table_count");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("table%0d_s", i), act_log[base+i].s, tbl[i].s);
      check($sformatf("table%0d_cout", i), act_log[base+i].cout, tbl[i].cout);
      check($sformatf("table%0d_ovf", i), act_log[base+i].ovf, tbl[i].ovf);
      check($sformatf("table%0d_latency", i), lat_log[lbase+i], 4);
    end

    // 8 random back-to-back ops with out_ready held high
    base = act_log.size();
    lbase = lat_log.size();
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
    in_valid = 0;
    wait_out(base + 8, "stream_count");
    for (int i = 0; i < 8; i++) check($sformatf("stream%0d_latency", i), lat_log[lbase+i], 4);

    // continuous offer with out_ready low: capacity and output hold
    out_ready = 0;
    base = act_log.size();
    acc = 0; bad = 0; have = 0; hold = '0;
    pa = $urandom; pb = $urandom; pc = 1'($urandom); ps = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      a = pa; b = pb; cin = pc; sub = ps; in_valid = 1;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        pa = $urandom; pb = $urandom; pc = 1'($urandom); ps = 1'($urandom);
      end
      if (out_valid) begin
        if (!have) begin
          have = 1;
          hold = {s, cout, ovf};
        end else if ({s, cout, ovf} !== hold) begin
          bad++;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    @(negedge clk);
    check("stall_accepted", acc, 4);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_hold_changes", bad, 0);
    @(posedge clk);
    #1;
    out_ready = 1;
    wait_out(base + 4, "stall_drain_count");
    repeat (6) @(posedge clk);
    #1;
    check("stall_no_dup", act_log.size(), base + 4);
    check("stall_queue_empty", eq.size(), 0);

    // asynchronous reset with three ops in flight
    out_ready = 0;
    send(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    send(32'h0F0F0F0F, 32'h01010101, 1'b1, 1'b0);
    send(32'h40000000, 32'h00000010, 1'b0, 1'b1);
    in_valid = 0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_pre_out_valid", out_valid, 1);
    rst = 1;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_s", s, 0);
    check("rst_async_cout", cout, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    out_ready = 1;
    base = act_log.size();
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    @(posedge clk);
    #1;
    lbase = lat_log.size();
    send(32'h00001234, 32'h00004321, 1'b1, 1'b0);
    in_valid = 0;
    wait_out(base + 1, "rst_after_count");
    check("rst_after_latency", lat_log[lbase], 4);
    check("rst_after_s", act_log[base].s, 32'h00005556);

    // wait for the 8-bit sweeps
    n = 0;
    while (!(g_small[0].done && g_small[1].done) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    check("small_done", (g_small[0].done && g_small[1].done), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
